gold_cdma_codec: RTL and testbench

Parametrised multi-channel Gold-code CDMA spreader/despreader. It is the next generation of the team's single-channel 5-bit Gold-code XOR block. It adds:
- configurable LFSR width and taps;
- N code channels taken from phase-shifted Gold sequences;
- a spreading factor (SF chips per data bit) with a symbol counter;
- a correlating integrate-and-dump receiver that recovers one bit per channel per symbol.

It sits between the bit-level data source/sink and the chip-level line interface.

---
 rtl/gold_cdma_pkg.sv | 31 +++
 rtl/gold_lfsr.sv | 34 +++
 rtl/gold_cdma_codec.sv | 144 ++++++++++++++
 tb/tb_gold_cdma_codec.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gold_cdma_pkg.sv
// Shared defaults and LFSR helpers for the multi-channel Gold-code CDMA codec.
// Functions work on a fixed maximum width; callers zero-extend and truncate.
// Pure combinational helpers; no state, no handshake.
package gold_cdma_pkg;

  localparam int LFSR_MAX_W = 16;

  localparam int         DEF_LFSR_W = 5;
  localparam logic [4:0] DEF_TAPS_A = 5'b11110;
  localparam logic [4:0] DEF_TAPS_B = 5'b10010;
  localparam int         DEF_N_CH   = 2;
  localparam int         DEF_SF     = 31;

  // Fibonacci step: shift left, feedback = parity of tapped bits.
  // Zero-extended inputs keep the parity exact; the bit shifted past the
  // caller's width is dropped by the caller's truncation.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
    input logic [LFSR_MAX_W-1:0] state,
    input logic [LFSR_MAX_W-1:0] taps
  );
    return {state[LFSR_MAX_W-2:0], ^(state & taps)};
  endfunction

  // An all-zero seed would lock the LFSR; substitute 1.
  function automatic logic [LFSR_MAX_W-1:0] gold_zero_guard(
    input logic [LFSR_MAX_W-1:0] seed
  );
    return (seed == '0) ? LFSR_MAX_W'(1) : seed;
  endfunction

endpackage

// File: rtl/gold_lfsr.sv
// Seedable Fibonacci LFSR; exposes the top OUT_W bits of its state (all of it by default).
// State updates one cycle after load/en; load has priority over en.
// No backpressure: steps on every en strobe.
module gold_lfsr
  import gold_cdma_pkg::*;
#(
  parameter int           W     = DEF_LFSR_W,
  parameter logic [W-1:0] TAPS  = W'(DEF_TAPS_A),
  parameter int           OUT_W = W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [W-1:0]     i_seed,
  input  logic             i_en,
  output logic [OUT_W-1:0] o_state
);

  logic [W-1:0] r_state;

  // Reset to all ones, load a zero-guarded seed, or advance one chip.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= '1;
    end else if (i_load) begin
      r_state <= W'(gold_zero_guard(LFSR_MAX_W'(i_seed)));
    end else if (i_en) begin
      r_state <= W'(lfsr_next(LFSR_MAX_W'(r_state), LFSR_MAX_W'(TAPS)));
    end
  end

  assign o_state = r_state[W-1 -: OUT_W];

endmodule

// File: rtl/gold_cdma_codec.sv
// N-channel Gold-code spreader with integrate-and-dump despreader (SF chips per bit).
// Chips appear 1 cycle after en_i; a decision pulses 1 cycle after the last valid rx chip.
// No backpressure: en_i is a chip strobe, low en_i freezes all symbol state.
module gold_cdma_codec
  import gold_cdma_pkg::*;
#(
  parameter int                LFSR_W = DEF_LFSR_W,
  parameter logic [LFSR_W-1:0] TAPS_A = LFSR_W'(DEF_TAPS_A),
  parameter logic [LFSR_W-1:0] TAPS_B = LFSR_W'(DEF_TAPS_B),
  parameter int                N_CH   = DEF_N_CH,
  parameter int                SF     = DEF_SF,
  parameter int                CNT_W  = $clog2(SF + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [LFSR_W-1:0] seed_i,
  input  logic              en_i,
  input  logic [N_CH-1:0]   bit_i,
  output logic              bit_take_o,
  output logic [N_CH-1:0]   chip_o,
  output logic              chip_valid_o,
  input  logic              rx_chip_i,
  output logic [N_CH-1:0]   rx_bit_o,
  output logic              rx_bit_valid_o,
  output logic              seed_zero_o
);

  localparam logic [CNT_W-1:0] LAST_CHIP = CNT_W'(SF - 1);
  localparam logic [CNT_W:0]   SF_X2     = (CNT_W + 1)'(SF);

  logic [0:0]      w_a_msb;
  logic [N_CH-1:0] w_b_top;     // w_b_top[N_CH-1-k] is B[LFSR_W-1-k]
  logic [N_CH-1:0] w_code;
  logic [N_CH-1:0] w_bits;
  logic            w_step;
  logic            w_take;
  logic            w_sym_end;

  logic [CNT_W-1:0] r_tx_cnt;
  logic [CNT_W-1:0] r_rx_cnt;
  logic [N_CH-1:0]  r_hold;
  logic [N_CH-1:0]  r_chip;
  logic [N_CH-1:0]  r_code_q;
  logic             r_chip_valid;
  logic             r_rx_valid;
  logic             r_seed_zero;

  gold_lfsr #(.W(LFSR_W), .TAPS(TAPS_A), .OUT_W(1)) u_lfsr_a (
    .i_clk(clk_i), .i_rst(rst_i), .i_load(load_i), .i_seed(seed_i),
    .i_en(en_i), .o_state(w_a_msb)
  );

  gold_lfsr #(.W(LFSR_W), .TAPS(TAPS_B), .OUT_W(N_CH)) u_lfsr_b (
    .i_clk(clk_i), .i_rst(rst_i), .i_load(load_i), .i_seed(seed_i),
    .i_en(en_i), .o_state(w_b_top)
  );

  assign w_step    = en_i & ~load_i;
  assign w_take    = w_step & (r_tx_cnt == '0);
  assign w_bits    = w_take ? bit_i : r_hold;   // first chip uses the fresh bit
  assign w_sym_end = r_chip_valid & (r_rx_cnt == LAST_CHIP);

  // bit_take_o is combinational so the source sees it in the sampling cycle;
  // gated by reset so every output is low while reset is held.
  assign bit_take_o     = w_take & ~rst_i;
  assign chip_o         = r_chip;
  assign chip_valid_o   = r_chip_valid;
  assign rx_bit_valid_o = r_rx_valid;
  assign seed_zero_o    = r_seed_zero;

  // Transmit side: symbol counter, bit hold, spread chips and delayed codes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tx_cnt     <= '0;
      r_hold       <= '0;
      r_chip       <= '0;
      r_code_q     <= '0;
      r_chip_valid <= 1'b0;
      r_seed_zero  <= 1'b0;
    end else if (load_i) begin
      r_tx_cnt     <= '0;
      r_chip_valid <= 1'b0;
      r_seed_zero  <= (seed_i == '0);
    end else begin
      r_chip_valid <= en_i;
      if (en_i) begin
        r_hold   <= w_bits;
        r_chip   <= w_bits ^ w_code;
        r_code_q <= w_code;
        r_tx_cnt <= (r_tx_cnt == LAST_CHIP) ? '0 : r_tx_cnt + CNT_W'(1);
      end
    end
  end

  // Receive side: counts valid chips and emits the decision strobe at symbol end.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rx_cnt   <= '0;
      r_rx_valid <= 1'b0;
    end else if (load_i) begin
      r_rx_cnt   <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_valid <= w_sym_end;
      if (r_chip_valid) begin
        r_rx_cnt <= w_sym_end ? '0 : r_rx_cnt + CNT_W'(1);
      end
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_corr
    logic [CNT_W-1:0] r_agree;
    logic             r_dec;
    logic             w_match;
    logic [CNT_W-1:0] w_total;

    // Channel 0 is the legacy Gold output (A msb ^ B msb).
    assign w_code[k] = w_a_msb[0] ^ w_b_top[N_CH-1-k];
    assign w_match   = (rx_chip_i == r_code_q[k]);
    assign w_total   = r_agree + CNT_W'(w_match);

    // Integrate agreements; a symbol mostly disagreeing with the code is a 1
    // (data 1 inverts the code). An exact tie (even SF only) decides 1.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_agree <= '0;
        r_dec   <= 1'b0;
      end else if (load_i) begin
        r_agree <= '0;
      end else if (r_chip_valid) begin
        if (w_sym_end) begin
          r_dec   <= ({w_total, 1'b0} <= SF_X2);
          r_agree <= '0;
        end else begin
          r_agree <= w_total;
        end
      end
    end

    assign rx_bit_o[k] = r_dec;
  end

endmodule

// File: tb/tb_gold_cdma_codec.sv
// Scoreboard bench: the stimulus process runs a behavioural model and queues
// expected chips / decisions; a negedge monitor pops and compares them.
// Channel 0 is looped back (optionally with injected chip inversions).
module tb_gold_cdma_codec;

  localparam int           W   = 5;
  localparam int           NCH = 2;
  localparam int           SF  = 31;
  localparam logic [W-1:0] TA  = 5'b11110;
  localparam logic [W-1:0] TB  = 5'b10010;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           load_i;
  logic [W-1:0]   seed_i;
  logic           en_i;
  logic [NCH-1:0] bit_i;
  logic           bit_take_o;
  logic [NCH-1:0] chip_o;
  logic           chip_valid_o;
  logic           rx_chip_i;
  logic [NCH-1:0] rx_bit_o;
  logic           rx_bit_valid_o;
  logic           seed_zero_o;
  logic           noise_cur;

  assign rx_chip_i = chip_o[0] ^ noise_cur;

  gold_cdma_codec #(
    .LFSR_W(W), .TAPS_A(TA), .TAPS_B(TB), .N_CH(NCH), .SF(SF)
  ) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .load_i(load_i), .seed_i(seed_i),
    .en_i(en_i), .bit_i(bit_i), .bit_take_o(bit_take_o), .chip_o(chip_o),
    .chip_valid_o(chip_valid_o), .rx_chip_i(rx_chip_i), .rx_bit_o(rx_bit_o),
    .rx_bit_valid_o(rx_bit_valid_o), .seed_zero_o(seed_zero_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc++;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [NCH-1:0] bits;
    int             cyc;
  } rx_exp_t;

  logic [NCH-1:0] q_chip[$];
  rx_exp_t        q_rx[$];

  // Behavioural model state
  logic [W-1:0]   ma, mb;
  int             mtx;
  logic [NCH-1:0] mhold;
  logic           exp_zero;
  logic           fl_vld, fl_noise;
  logic [NCH-1:0] fl_chip, fl_code, fl_bits;
  int             rx_n, ninv;
  int             agree[NCH];
  logic [NCH-1:0] sym_bits;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Spec rule: shift left, new lsb = parity of tapped bits.
  function automatic logic [W-1:0] adv(input logic [W-1:0] s, input logic [W-1:0] t);
    int fb;
    fb = $countones(s & t) % 2;
    return W'((int'(s) * 2 + fb) % (1 << W));
  endfunction

  task automatic clear_sym();
    rx_n = 0;
    ninv = 0;
    for (int k = 0; k < NCH; k++) agree[k] = 0;
  endtask

  task automatic model_reset();
    ma = '1; mb = '1; mtx = 0; mhold = '0; exp_zero = 1'b0;
    fl_vld = 1'b0; fl_noise = 1'b0; noise_cur = 1'b0;
    clear_sym();
    q_chip.delete();
    q_rx.delete();
  endtask

  // One clock of stimulus; called at posedge+1, returns at next posedge+1.
  task automatic step(input logic en, input logic ld, input logic [W-1:0] seed,
                      input logic [NCH-1:0] bits, input logic nz);
    logic           exp_take;
    logic           rxc;
    logic [NCH-1:0] code, chip;
    rx_exp_t        e;
    exp_take = 1'b0;
    check("seed_zero", seed_zero_o, exp_zero);
    noise_cur = fl_vld ? fl_noise : 1'b0;
    // Chip emitted last cycle is received this cycle unless a load discards it.
    if (fl_vld && !ld) begin
      rxc = fl_chip[0] ^ fl_noise;
      if (rx_n == 0) sym_bits = fl_bits;
      ninv += int'(fl_noise);
      for (int k = 0; k < NCH; k++) if (rxc == fl_code[k]) agree[k]++;
      rx_n++;
      if (rx_n == SF) begin
        e.bits[0] = sym_bits[0] ^ (2 * ninv > SF);   // majority of chips inverted flips the bit
        for (int k = 1; k < NCH; k++) e.bits[k] = (2 * agree[k] <= SF);
        e.cyc = cyc + 1;
        q_rx.push_back(e);
        clear_sym();
      end
    end
    fl_vld = 1'b0;
    if (ld) begin
      clear_sym();
      ma = (seed == '0) ? W'(1) : seed;
      mb = ma;
      mtx = 0;
      exp_zero = (seed == '0);
    end else if (en) begin
      exp_take = (mtx == 0);
      if (exp_take) mhold = bits;
      for (int k = 0; k < NCH; k++) code[k] = ma[W-1] ^ mb[W-1-k];
      chip = mhold ^ code;
      q_chip.push_back(chip);
      fl_vld = 1'b1; fl_chip = chip; fl_code = code; fl_bits = mhold; fl_noise = nz;
      ma = adv(ma, TA);
      mb = adv(mb, TB);
      mtx = (mtx + 1) % SF;
    end
    en_i = en; load_i = ld; seed_i = seed; bit_i = bits;
    #1 check("bit_take", bit_take_o, exp_take);
    @(posedge clk_i);
    #1;
  endtask

  // Asynchronous reset asserted in the middle of a cycle.
  task automatic reset_mid();
    #2 rst_i = 1'b1;
    #1;
    model_reset();
    check("rst_outs", {bit_take_o, chip_o, chip_valid_o, rx_bit_o, rx_bit_valid_o, seed_zero_o}, 0);
    check("rst_A", u_dut.u_lfsr_a.r_state, 5'b11111);
    check("rst_B", u_dut.u_lfsr_b.r_state, 5'b11111);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
  endtask

  // Monitor: compare whatever the DUT presents against the queued expectations.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (chip_valid_o) begin
        if (q_chip.size() == 0) check("chip_unexpected", 1, 0);
        else check("chip", chip_o, q_chip.pop_front());
      end
      if (rx_bit_valid_o) begin
        if (q_rx.size() == 0) begin
          check("rx_unexpected", 1, 0);
        end else begin
          rx_exp_t e;
          e = q_rx.pop_front();
          check("rx_bit", rx_bit_o, e.bits);
          check("rx_latency", cyc, e.cyc);
        end
      end
    end
  end

  int pat[4] = '{1, 0, 1, 1};
  logic [NCH-1:0] b;

  initial begin
    rst_i = 1'b1; load_i = 1'b0; en_i = 1'b0; seed_i = '0; bit_i = '0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Run a little, then reset mid-symbol with en_i still high.
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, '0, NCH'($urandom), 1'b0);
    en_i = 1'b1;
    reset_mid();

    // Zero seed: substituted with 1 and the sequence keeps moving.
    step(1'b0, 1'b1, 5'b00000, '0, 1'b0);
    check("zero_flag", seed_zero_o, 1);
    check("zero_A", u_dut.u_lfsr_a.r_state, 5'b00001);
    check("zero_B", u_dut.u_lfsr_b.r_state, 5'b00001);
    repeat (3) step(1'b1, 1'b0, '0, NCH'($urandom), 1'b0);
    check("zero_adv_A", u_dut.u_lfsr_a.r_state, ma);
    check("zero_adv_B", u_dut.u_lfsr_b.r_state, mb);

    // Seed load then one step.
    step(1'b0, 1'b1, 5'b10101, '0, 1'b0);
    check("load_A", u_dut.u_lfsr_a.r_state, 5'b10101);
    b = NCH'($urandom);
    step(1'b1, 1'b0, '0, b, 1'b0);
    check("step_A", u_dut.u_lfsr_a.r_state, 5'b01010);
    check("step_B", u_dut.u_lfsr_b.r_state, 5'b01011);
    check("step_chip0", chip_o[0], b[0]);        // code0 = 1^1 = 0

    // Loopback bits 1,0,1,1 on channel 0.
    step(1'b0, 1'b1, W'($urandom_range(1, 31)), '0, 1'b0);
    for (int s = 0; s < 4; s++)
      for (int c = 0; c < SF; c++)
        step(1'b1, 1'b0, '0, {1'($urandom), 1'(pat[s])}, 1'b0);

    // Noise: 15 inverted chips keep the decision, 16 flip it.
    for (int s = 0; s < 2; s++) begin
      b = NCH'($urandom);
      for (int c = 0; c < SF; c++)
        step(1'b1, 1'b0, '0, b, (c < 15 + s));
    end

    // Mid-symbol load at chip 10: aborted symbol yields no decision.
    for (int c = 0; c < 10; c++) step(1'b1, 1'b0, '0, NCH'($urandom), 1'b0);
    step(1'b1, 1'b1, W'($urandom), '0, 1'b0);
    for (int c = 0; c < SF + 5; c++) step(1'b1, 1'b0, '0, NCH'($urandom), 1'b0);

    // Randomized traffic with gaps, loads, noise and one mid-run reset.
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) reset_mid();
      step(($urandom % 8) != 0, ($urandom % 200) == 0, W'($urandom),
           NCH'($urandom), ($urandom % 6) == 0);
    end

    repeat (3) step(1'b0, 1'b0, '0, '0, 1'b0);
    check("chip_queue_empty", q_chip.size(), 0);
    check("rx_queue_empty", q_rx.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
